// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - dual-issue instruction buffer and pairing scheduler
// Optional issue statistics counters are built when ISSUE_STATS_EN is defined.
module issue_scheduler #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [1:0]      in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc0,
    input  logic [PC_W-1:0] in_pc1,
    input  logic [31:0]     in_instr0,
    input  logic [31:0]     in_instr1,
    input  logic [18:0]     in_info0,
    input  logic [18:0]     in_info1,
    input  logic            stall,
    input  logic            flush,
`ifdef ISSUE_STATS_EN
    output logic [31:0]     stat_dual,
    output logic [31:0]     stat_single,
    output logic [31:0]     stat_bubble,
`endif
    output logic            out_valid0,
    output logic            out_valid1,
    output logic [PC_W-1:0] out_pc0,
    output logic [PC_W-1:0] out_pc1,
    output logic [31:0]     out_instr0,
    output logic [31:0]     out_instr1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic [18:0]     mem_info  [DEPTH];

    logic [AW-1:0]   head, tail, head1, tail1;
    logic [CW-1:0]   count;
    logic [PC_W-1:0] hold_pc0, hold_pc1;
    logic [31:0]     hold_instr0, hold_instr1;

    logic            do_push;
    logic [1:0]      push_n, pop_n;
    logic            pair_ok;

    // Predecode fields of the two head entries: {rs1, rs2, rd, regwrite, is_mem, is_br, is_csr}
    logic [4:0]      e0_rd, e1_rs1, e1_rs2;
    logic            e0_rw, e0_mem, e0_br, e0_csr;
    logic            e1_mem, e1_br, e1_csr;

    assign head1 = head + AW'(1);
    assign tail1 = tail + AW'(1);

    assign e0_rd  = mem_info[head][8:4];
    assign e0_rw  = mem_info[head][3];
    assign e0_mem = mem_info[head][2];
    assign e0_br  = mem_info[head][1];
    assign e0_csr = mem_info[head][0];
    assign e1_rs1 = mem_info[head1][18:14];
    assign e1_rs2 = mem_info[head1][13:9];
    assign e1_mem = mem_info[head1][2];
    assign e1_br  = mem_info[head1][1];
    assign e1_csr = mem_info[head1][0];

    always_comb begin
        pair_ok = 1'b1;
        if (e0_br || e0_csr || e1_br || e1_csr) begin
            pair_ok = 1'b0;
        end
        if (e0_mem && e1_mem) begin
            pair_ok = 1'b0;
        end
        if (e0_rw && (e0_rd != 5'd0) && ((e1_rs1 == e0_rd) || (e1_rs2 == e0_rd))) begin
            pair_ok = 1'b0;
        end
    end

    assign in_ready = (count <= CW'(DEPTH - 2));
    assign do_push  = in_ready && in_valid[0] && !flush;
    assign push_n   = do_push ? (in_valid[1] ? 2'd2 : 2'd1) : 2'd0;

    assign out_valid0 = (count != '0) && !stall && !flush;
    assign out_valid1 = out_valid0 && (count >= CW'(2)) && pair_ok;
    assign pop_n      = {1'b0, out_valid0} + {1'b0, out_valid1};

    // Show-ahead head entries; with too few entries the last shown value is held.
    assign out_pc0    = (count != '0)       ? mem_pc[head]     : hold_pc0;
    assign out_instr0 = (count != '0)       ? mem_instr[head]  : hold_instr0;
    assign out_pc1    = (count >= CW'(2))   ? mem_pc[head1]    : hold_pc1;
    assign out_instr1 = (count >= CW'(2))   ? mem_instr[head1] : hold_instr1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_pc[tail]    <= in_pc0;
            mem_instr[tail] <= in_instr0;
            mem_info[tail]  <= in_info0;
            if (in_valid[1]) begin
                mem_pc[tail1]    <= in_pc1;
                mem_instr[tail1] <= in_instr1;
                mem_info[tail1]  <= in_info1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            hold_pc0    <= '0;
            hold_pc1    <= '0;
            hold_instr0 <= '0;
            hold_instr1 <= '0;
        end else begin
            hold_pc0    <= out_pc0;
            hold_pc1    <= out_pc1;
            hold_instr0 <= out_instr0;
            hold_instr1 <= out_instr1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + AW'(pop_n);
                tail  <= tail + AW'(push_n);
                count <= count + CW'(push_n) - CW'(pop_n);
            end
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_dual   <= '0;
            stat_single <= '0;
            stat_bubble <= '0;
        end else if (out_valid1) begin
            if (stat_dual != '1) stat_dual <= stat_dual + 32'd1;
        end else if (out_valid0) begin
            if (stat_single != '1) stat_single <= stat_single + 32'd1;
        end else if (!stall) begin
            if (stat_bubble != '1) stat_bubble <= stat_bubble + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - randomized scoreboard bench for issue_scheduler
module tb_issue_scheduler;
    localparam int DEPTH = 8;
    localparam int PC_W  = 64;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [1:0]      in_valid = '0;
    logic            in_ready;
    logic [PC_W-1:0] in_pc0 = '0, in_pc1 = '0;
    logic [31:0]     in_instr0 = '0, in_instr1 = '0;
    logic [18:0]     in_info0 = '0, in_info1 = '0;
    logic            stall = 1'b0, flush = 1'b0;
    logic            out_valid0, out_valid1;
    logic [PC_W-1:0] out_pc0, out_pc1;
    logic [31:0]     out_instr0, out_instr1;
`ifdef ISSUE_STATS_EN
    logic [31:0]     stat_dual, stat_single, stat_bubble;
`endif

    issue_scheduler #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc0(in_pc0), .in_pc1(in_pc1),
        .in_instr0(in_instr0), .in_instr1(in_instr1),
        .in_info0(in_info0), .in_info1(in_info1),
        .stall(stall), .flush(flush),
`ifdef ISSUE_STATS_EN
        .stat_dual(stat_dual), .stat_single(stat_single), .stat_bubble(stat_bubble),
`endif
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_pc0(out_pc0), .out_pc1(out_pc1),
        .out_instr0(out_instr0), .out_instr1(out_instr1)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic [31:0] instr; logic [18:0] info; } ent_t;
    typedef struct { int lane; logic [63:0] pc; logic [31:0] instr; } iss_t;

    ent_t        mq[$];
    iss_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    bit          exp_ready = 1;
    bit          hold = 0;
    logic [1:0]  last_v = '0;
    logic [63:0] next_pc = 64'h1000;
    logic [63:0] m_dual = '0, m_single = '0, m_bubble = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] mk_info(input int rs1, input int rs2, input int rd,
                                            input bit rw, input bit mem, input bit br, input bit csr);
        return {5'(rs1), 5'(rs2), 5'(rd), rw, mem, br, csr};
    endfunction

    function automatic logic [18:0] rnd_info();
        return mk_info($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    endfunction

    // Two instructions may share a cycle unless a branch/CSR is involved, both touch memory,
    // or the younger one reads a nonzero register the older one writes.
    function automatic bit pairable(input ent_t a, input ent_t b);
        int a_rd, b_rs1, b_rs2;
        a_rd  = int'(a.info[8:4]);
        b_rs1 = int'(b.info[18:14]);
        b_rs2 = int'(b.info[13:9]);
        if (a.info[1] || a.info[0] || b.info[1] || b.info[0]) return 0;
        if (a.info[2] && b.info[2]) return 0;
        if (a.info[3] && a_rd != 0 && (b_rs1 == a_rd || b_rs2 == a_rd)) return 0;
        return 1;
    endfunction

    task automatic step(input logic [1:0] v, input bit st, input bit fl,
                        input bit fix, input logic [18:0] i0, input logic [18:0] i1);
        int n;
        @(negedge clk);
        if (!hold) begin
            in_pc0    = next_pc;
            in_pc1    = next_pc + 64'd4;
            next_pc   = next_pc + 64'd8;
            in_instr0 = $urandom;
            in_instr1 = $urandom;
            in_info0  = fix ? i0 : rnd_info();
            in_info1  = fix ? i1 : rnd_info();
        end
        in_valid = v;
        stall    = st;
        flush    = fl;
        last_v   = v;
        #1;
        exp_ready = (DEPTH - mq.size() >= 2);
        n = 0;
        if (!st && !fl && mq.size() >= 1) begin
            n = 1;
            if (mq.size() >= 2 && pairable(mq[0], mq[1])) n = 2;
        end
        for (int i = 0; i < n; i++) begin
            ent_t e;
            e = mq.pop_front();
            sb.push_back('{lane: i, pc: e.pc, instr: e.instr});
        end
        if (n == 2) m_dual++;
        else if (n == 1) m_single++;
        else if (!st) m_bubble++;
        if (fl) begin
            mq.delete();
        end else if (exp_ready && v[0]) begin
            mq.push_back('{pc: in_pc0, instr: in_instr0, info: in_info0});
            if (v[1]) mq.push_back('{pc: in_pc1, instr: in_instr1, info: in_info1});
        end
        hold = v[0] && !exp_ready && !fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 0, 0, 0, '0, '0);
    endtask

    task automatic check_stats();
`ifdef ISSUE_STATS_EN
        chk("stat_dual", stat_dual, m_dual);
        chk("stat_single", stat_single, m_single);
        chk("stat_bubble", stat_bubble, m_bubble);
`endif
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("in_ready", in_ready, exp_ready);
                chk("lane1_without_lane0", out_valid1 & ~out_valid0, 0);
                for (int lane = 0; lane < 2; lane++) begin
                    logic vl;
                    vl = (lane == 0) ? out_valid0 : out_valid1;
                    if (vl) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_issue lane %0d: got valid expected idle at %0t", lane, $time);
                        end else begin
                            iss_t e;
                            e = sb.pop_front();
                            chk("issue_lane", lane, e.lane);
                            chk("issue_pc", (lane == 0) ? out_pc0 : out_pc1, e.pc);
                            chk("issue_instr", (lane == 0) ? out_instr0 : out_instr1, e.instr);
                        end
                    end
                end
                chk("missing_issue", sb.size(), 0);
                sb.delete();
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        mon_en   = 0;
        in_valid = '0;
        stall    = 0;
        flush    = 0;
        resetn   = 0;
        #1;
        chk("rst_out_valid0", out_valid0, 0);
        chk("rst_out_valid1", out_valid1, 0);
        chk("rst_out_pc0", out_pc0, 0);
        chk("rst_out_instr1", out_instr1, 0);
`ifdef ISSUE_STATS_EN
        chk("rst_stat_dual", stat_dual, 0);
        chk("rst_stat_single", stat_single, 0);
        chk("rst_stat_bubble", stat_bubble, 0);
`endif
        mq.delete();
        sb.delete();
        hold     = 0;
        m_dual   = '0;
        m_single = '0;
        m_bubble = '0;
        exp_ready = 1;
        @(posedge clk);
        #1;
        resetn = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        mon_en = 1;
    endtask

    initial begin : main
        apply_reset();

        // Independent ALU pair, then RAW-dependent pair
        step(2'b11, 0, 0, 1, mk_info(2, 3, 1, 1, 0, 0, 0), mk_info(5, 6, 4, 1, 0, 0, 0));
        idle(2);
        step(2'b11, 0, 0, 1, mk_info(2, 3, 1, 1, 0, 0, 0), mk_info(1, 4, 7, 1, 0, 0, 0));
        idle(3);
        // Load/store pair, then branch followed by ALU
        step(2'b11, 0, 0, 1, mk_info(2, 0, 5, 1, 1, 0, 0), mk_info(3, 6, 0, 0, 1, 0, 0));
        idle(3);
        step(2'b11, 0, 0, 1, mk_info(1, 2, 0, 0, 0, 1, 0), mk_info(5, 6, 4, 1, 0, 0, 0));
        idle(3);

        // Fill to 7 under stall, refused pair, drain across the wrap point
        for (int i = 0; i < 3; i++) step(2'b11, 1, 0, 0, '0, '0);
        step(2'b01, 1, 0, 0, '0, '0);
        step(2'b11, 1, 0, 0, '0, '0);
        idle(9);
        // Fill to 8 under stall, refused attempts, drain
        for (int i = 0; i < 4; i++) step(2'b11, 1, 0, 0, '0, '0);
        step(2'b11, 1, 0, 0, '0, '0);
        step(2'b01, 1, 0, 0, '0, '0);
        idle(9);

        // Count 5 then flush with a same-cycle pair
        step(2'b11, 1, 0, 0, '0, '0);
        step(2'b11, 1, 0, 0, '0, '0);
        step(2'b01, 1, 0, 0, '0, '0);
        step(2'b11, 0, 1, 0, '0, '0);
        idle(3);

        @(posedge clk);
        #1;
        check_stats();
        apply_reset();

        for (int c = 0; c < 3000; c++) begin
            logic [1:0] v;
            int r;
            r = $urandom_range(0, 3);
            v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            if (hold) v = last_v;
            step(v, $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0, 0, '0, '0);
        end
        idle(10);

        @(posedge clk);
        #1;
        check_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
